// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the binary-to-one-hot decoder and its encoder-side checkers.
package onehot_decoder_pkg;

  typedef enum logic [0:0] {IDLE, DRIVE} state_e;

  localparam int unsigned MaxCodeW = 8;
  localparam int unsigned MaxOutW  = 2 ** MaxCodeW;

  // Callers truncate the result to their own OUT_W.
  function automatic logic [MaxOutW-1:0] decode_onehot(input logic [MaxCodeW-1:0] code);
    return MaxOutW'(1) << code;
  endfunction

endpackage

// File: rtl/onehot_decoder_pend_slot.sv
// One-entry pending code register; in_ready is high whenever the slot is empty.
module decoder_pend_slot
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [CODE_W-1:0] wr_code,
  output logic [CODE_W-1:0] pend_code,
  output logic              pend_valid,
  output logic              in_ready
);

  logic              valid_q;
  logic [CODE_W-1:0] code_q;

  // wr and rd are never both set: wr needs an empty slot, rd a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else if (wr) begin
      valid_q <= 1'b1;
      code_q  <= wr_code;
    end else if (rd) begin
      valid_q <= 1'b0;
    end
  end

  assign pend_code  = code_q;
  assign pend_valid = valid_q;
  assign in_ready   = !valid_q;

endmodule

// File: rtl/onehot_decoder.sv
// Sequential binary-to-one-hot decoder: each accepted code drives its line for HOLD cycles,
// with a one-entry pending slot so back-to-back codes come out without gaps.
module onehot_decoder
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned CODE_W = 2,
  parameter int unsigned OUT_W  = 2 ** CODE_W,
  parameter int unsigned HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [OUT_W-1:0]  out_onehot,
  output logic              out_valid,
  output logic              busy,
  output logic [7:0]        dec_count
);

  if (HOLD < 1) begin : g_hold_chk
    $error("onehot_decoder: HOLD must be at least 1");
  end
  if (OUT_W != 2 ** CODE_W) begin : g_outw_chk
    $error("onehot_decoder: OUT_W is derived and must equal 2**CODE_W");
  end
  if (CODE_W > MaxCodeW) begin : g_codew_chk
    $error("onehot_decoder: CODE_W exceeds package limit");
  end

  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);

  state_e            state_q;
  logic [HoldW-1:0]  hold_q;
  logic [OUT_W-1:0]  out_q;
  logic              valid_q;
  logic [7:0]        count_q;

  logic              xfer;
  logic              last_cycle;
  logic              pend_wr;
  logic              pend_rd;
  logic              load;
  logic [CODE_W-1:0] load_code;
  logic [CODE_W-1:0] pend_code;
  logic              pend_valid;

  decoder_pend_slot #(
    .CODE_W(CODE_W)
  ) u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (pend_wr),
    .rd        (pend_rd),
    .wr_code   (in_code),
    .pend_code (pend_code),
    .pend_valid(pend_valid),
    .in_ready  (in_ready)
  );

  always_comb begin
    xfer       = in_valid && in_ready;
    last_cycle = (state_q == DRIVE) && (hold_q == '0);
    pend_wr    = xfer && (state_q == DRIVE) && (hold_q != '0);
    pend_rd    = last_cycle && pend_valid;
    // A full slot always wins the reload; in_ready is low then, so xfer cannot also fire.
    load       = ((state_q == IDLE) && xfer) || (last_cycle && (pend_valid || xfer));
    load_code  = pend_valid ? pend_code : in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (load) begin
      state_q <= DRIVE;
      hold_q  <= HoldLast;
      out_q   <= OUT_W'(decode_onehot(MaxCodeW'(load_code)));
      valid_q <= 1'b1;
      count_q <= count_q + 8'd1;
    end else begin
      unique case (state_q)
        IDLE: begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end
        DRIVE: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_onehot = out_q;
  assign out_valid  = valid_q;
  assign busy       = valid_q || pend_valid;
  assign dec_count  = count_q;

endmodule

// File: doc/onehot_decoder.md
# onehot_decoder

Sequential N-to-2^N decoder, the counterpart of the team's one-hot-to-binary encoder. It accepts binary codes over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. A one-entry pending slot lets back-to-back codes produce gap-free output. It sits on the receive side of an encoder link, where it regenerates the one-hot select lines for downstream logic.

## Interface
- CODE_W, default 2: input code width.
- OUT_W, default 2**CODE_W: one-hot output width. Derived; must not be overridden.
- HOLD, default 4: cycles each decoded line stays asserted. Must be ≥1; elaboration error otherwise.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  CODE_W  binary code to decode.
- out_onehot  output  OUT_W  decoded line; bit in_code set, all others 0. All-zero when idle.
- out_valid  output  1  out_onehot currently carries a decoded code.
- busy  output  1  out_valid OR pending slot occupied.
- dec_count  output  8  number of codes driven to the output; wraps modulo 256.

## Operation
- Transfer occurs when in_valid && in_ready. in_code is sampled on that edge only.
- in_ready = !pend_valid. It is combinational from state only, with no path from in_valid.
- FSM states:
  - IDLE: out_valid=0, out_onehot=0.
    - A transfer loads out_onehot = 1<<in_code and hold_cnt = HOLD-1, then moves to DRIVE.
  - DRIVE: out_valid=1. Each cycle with hold_cnt>0, hold_cnt decrements. When hold_cnt==0:
    - If pend_valid: load out_onehot from the pending code, clear pend_valid, set hold_cnt = HOLD-1, stay in DRIVE.
    - Else if a transfer occurs this cycle: load directly from in_code, set hold_cnt = HOLD-1, stay in DRIVE.
    - Else: go to IDLE with out_onehot=0.
- A transfer in DRIVE with hold_cnt>0 writes the pending slot: pend_code = in_code, pend_valid = 1.
- Pending full (in_ready=0): in_valid is ignored. The source must hold in_code stable until in_ready returns.
- dec_count increments by 1 on every output load (IDLE→DRIVE or reload in DRIVE). 255 wraps to 0.
- No illegal codes exist: every CODE_W value maps to exactly one output bit.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - State IDLE, out_onehot=0, out_valid=0, busy=0, in_ready=1, dec_count=0, pend_valid=0, hold_cnt=0.
- Reset mid-operation drops both the active code and the pending code. After release the block is idle. Nothing is counted.
- Latency: a transfer at edge t gives out_onehot valid from cycle t+1, asserted for exactly HOLD consecutive cycles.
- Throughput: consecutive codes appear with no idle cycle between them, provided each arrives before the previous one's final hold cycle ends.
  - HOLD=1 gives a sustained one code per cycle through the direct-load path; the pending slot never fills.
- Pending slot freed at edge t: in_ready is high in cycle t+1.
- Simultaneous final hold cycle, pending full, and in_valid=1: the pending code is loaded. The input is not accepted (in_ready=0).

## Structure
- Package onehot_decoder_pkg holds:
  - FSM state enum: IDLE, DRIVE.
  - Function `decode_onehot(code)` returning 1<<code at OUT_W width; the encoder side may also use it for checking.
- Natural sub-module: decoder_pend_slot, the one-entry pending register with valid flag and in_ready generation.
- Hold counter width is $clog2(HOLD) (minimum 1 bit). FSM and output register stay in the top level.

## Test plan
- Reset: rst_n low mid-DRIVE, with pending full → all outputs return to reset values at once; in_ready=1 and dec_count=0 after release.
- Single code, HOLD=4: send code 2 at cycle 0 → out_onehot=4'b0100 with out_valid=1 for cycles 1–4, 0 at cycle 5; dec_count=1.
- Back-to-back, HOLD=4: send code 0, then code 3 one cycle later → 0001 for 4 cycles, then immediately 1000 for 4 cycles. in_ready is low from the second transfer until the pending code loads.
- Backpressure: with pending full, hold in_valid=1, code 1, for 3 cycles → no extra transfer occurs; code 1 is accepted only on the first cycle in_ready=1 and is driven once.
- HOLD=1 streaming: codes 0, 1, 2, 3 on consecutive cycles → out_onehot 0001, 0010, 0100, 1000 on consecutive cycles; in_ready stays 1.
- Wrap: 256 transfers → dec_count returns to 0; the 257th transfer sets it to 1.
